// File: rtl/lower_triangular_expand.sv
// Expands a packed row-major lower-triangular stream back to a full SIZE x SIZE
// matrix, inserting zeros above the diagonal. Single registered output stage.
//
// state | meaning
// PASS  | current position is on/below the diagonal; forward the next input
// ZERO  | current position is above the diagonal; emit a zero, stall input
module lower_triangular_expand #(
  parameter int SIZE       = 5,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] in_tdata,
  input  logic                  in_tvalid,
  output logic                  in_tready,
  output logic [DATA_WIDTH-1:0] out_tdata,
  output logic                  out_tvalid,
  input  logic                  out_tready,
  output logic                  out_tlast
);

  localparam int CW = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam logic [CW-1:0] LAST = CW'(SIZE - 1);

  typedef enum logic {
    PASS = 1'b0,
    ZERO = 1'b1
  } state_t;

  state_t                state, state_nxt;
  logic [CW-1:0]         row, row_nxt;
  logic [CW-1:0]         col, col_nxt;
  logic [DATA_WIDTH-1:0] data_nxt;
  logic                  valid_nxt;
  logic                  last_nxt;
  logic                  load_en;

  // No path from in_tvalid: ready depends only on the output register and state.
  assign load_en   = (!out_tvalid || out_tready) && !rst;
  assign in_tready = load_en && (state == PASS);

  always_comb begin
    state_nxt = state;
    row_nxt   = row;
    col_nxt   = col;
    data_nxt  = out_tdata;
    valid_nxt = out_tvalid;
    last_nxt  = out_tlast;

    if (load_en) begin
      unique case (state)
        PASS: begin
          if (in_tvalid) begin
            data_nxt  = in_tdata;
            valid_nxt = 1'b1;
            last_nxt  = (row == LAST) && (col == LAST);
            if (col < row) begin
              col_nxt = col + CW'(1);
            end else if (row == LAST) begin
              row_nxt = '0;
              col_nxt = '0;
            end else begin
              col_nxt   = row + CW'(1);
              state_nxt = ZERO;
            end
          end else begin
            valid_nxt = 1'b0;
          end
        end
        ZERO: begin
          data_nxt  = '0;
          valid_nxt = 1'b1;
          last_nxt  = 1'b0;
          if (col < LAST) begin
            col_nxt = col + CW'(1);
          end else begin
            row_nxt   = row + CW'(1);
            col_nxt   = '0;
            state_nxt = PASS;
          end
        end
        default: state_nxt = PASS;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= PASS;
      row        <= '0;
      col        <= '0;
      out_tdata  <= '0;
      out_tvalid <= 1'b0;
      out_tlast  <= 1'b0;
    end else begin
      state      <= state_nxt;
      row        <= row_nxt;
      col        <= col_nxt;
      out_tdata  <= data_nxt;
      out_tvalid <= valid_nxt;
      out_tlast  <= last_nxt;
    end
  end

endmodule

// File: doc/lower_triangular_expand.md
Name: lower_triangular_expand

Overview:
- Inverse of the lower-triangular packer in the matrix manipulation IP.
- Accepts a packed row-major stream of the SIZE*(SIZE+1)/2 on-or-below-diagonal elements of a SIZE x SIZE matrix.
- Emits the full SIZE*SIZE matrix row-major, inserting zeros for every above-diagonal position.
- Sits downstream of lower_triangular on a valid/ready stream; a loopback through both reconstructs the masked matrix.

Parameters:
SIZE, 5, matrix dimension (rows = cols), legal range 1..15
DATA_WIDTH, 8, element width in bits

Ports:
clk  input  1  clock; all logic on rising edge
rst  input  1  synchronous, active-high reset
in_tdata  input  DATA_WIDTH  packed element
in_tvalid  input  1  in_tdata valid
in_tready  output  1  block accepts in_tdata this cycle
out_tdata  output  DATA_WIDTH  expanded element
out_tvalid  output  1  out_tdata valid
out_tready  input  1  downstream accepts out_tdata
out_tlast  output  1  high with last element (row=col=SIZE-1) of each matrix

Behaviour:
- Reset (rst high at clock edge): out_tvalid=0, out_tdata=0, out_tlast=0, row=0, col=0, state=PASS. in_tready is 0 while rst is high. Reset mid-matrix discards the partial matrix; the next accepted input is element (0,0).
- Output stage: a single register. load_en = (!out_tvalid || out_tready) && !rst.
- in_tready = load_en && (state==PASS). This is combinational from out_tvalid/out_tready/state, with no combinational path from in_tvalid.
- FSM states:
  - PASS: position col<=row.
  - ZERO: position col>row.
- PASS:
  - On load_en && in_tvalid: out_tdata<=in_tdata, out_tvalid<=1, out_tlast<=(row==SIZE-1 && col==SIZE-1).
  - If col<row: col++.
  - If col==row and row==SIZE-1: row=0, col=0, stay PASS (matrix end).
  - If col==row and row<SIZE-1: col=row+1, go to ZERO.
  - On load_en && !in_tvalid: out_tvalid<=0, counters hold. No zero is inserted ahead of the pending data.
- ZERO:
  - On load_en: out_tdata<=0, out_tvalid<=1, out_tlast<=0, independent of in_tvalid.
  - If col<SIZE-1: col++.
  - Else: row++, col=0, go to PASS.
- Hold: when out_tvalid && !out_tready, out_tdata/out_tlast/out_tvalid, counters and state are held unchanged.
- Latency: one cycle from input handshake to out_tvalid.
- Throughput: one output element per cycle when out_tready stays high and in_tvalid is high in PASS.
- Counters: ceil(log2(SIZE)) bits. The wrap at row=col=SIZE-1 allows back-to-back matrices with no idle cycle.
- SIZE=1: ZERO is never entered; every element passes with out_tlast=1.
- Per matrix: exactly SIZE*(SIZE+1)/2 input handshakes and SIZE*SIZE output handshakes.

Test Plan:
- Basic expand:
  - Stimulus: SIZE=5, DATA_WIDTH=8, out_tready=1, inputs 1..15 back-to-back.
  - Response: 25 outputs 1,0,0,0,0, 2,3,0,0,0, 4,5,6,0,0, 7,8,9,10,0, 11,12,13,14,15. out_tlast only on the 25th. in_tready low during each zero run.
- Back-pressure:
  - Stimulus: out_tready low for 2 cycles while output #7 (value 3) is valid.
  - Response: out_tdata=3 and out_tvalid held for those cycles, in_tready=0, no element lost or duplicated, sequence as above.
- Input gaps:
  - Stimulus: in_tvalid low for 3 cycles before input 7.
  - Response: out_tvalid drops after the zero at position (2,4) and no further zeros appear; then 7 is emitted, followed by 8,9,10,0.
- Reset mid-matrix:
  - Stimulus: assert rst for 1 cycle after 8 inputs.
  - Response: out_tvalid=0 and in_tready=0 during reset. Then inputs 101..115 produce a clean matrix starting 101,0,0,0,0.
- Back-to-back matrices:
  - Stimulus: 30 continuous inputs.
  - Response: 50 outputs with out_tlast at #25 and #50; the second matrix begins with input 16 then four zeros.
- Random:
  - Stimulus: random in_tvalid/out_tready over 20 matrices.
  - Response: scoreboard matches the zero-filled lower-triangular reference model exactly.
